// File: rtl/store_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : store_rmw_ctrl
//  Purpose  : Store sequencer placed directly ahead of the memory write port.
//             Word stores (sw) issue a single write. Halfword (sh) and byte
//             (sb) stores read the addressed word, merge the new low
//             halfword/byte into it and write the merged word back.
//             busy stalls the control unit for the whole transaction; done
//             pulses for one cycle once the store has landed.
//  Ports    : clk         - clock, rising edge
//             reset_n     - asynchronous active-low reset
//             start       - store request, sampled only in IDLE
//             store_type  - 1x = word, 01 = halfword, 00 = byte
//             addr        - store address (passed through unmodified)
//             store_data  - source register value
//             mem_rdata   - memory read data
//             mem_addr    - memory address (0 outside READ/WRITE)
//             mem_wr      - memory write strobe (WRITE state only)
//             mem_wdata   - memory write data (merge register in WRITE, else 0)
//             busy        - transaction in progress (READ/WRITE)
//             done        - one-cycle completion pulse (DONE state)
//  Params   : RD_WAIT     - memory read latency in cycles, 1..15
//  Revision : 1.0 - initial release
// ============================================================================
module store_rmw_ctrl #(
  parameter int RD_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done
);

  // 4-bit wait counter compare value; legal latency range is 1..15.
  localparam logic [3:0] c_rd_wait = 4'(RD_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_type;
  logic [3:0]  r_cnt;
  logic [31:0] r_merge;

  // Merged word: upper bits come from memory, new data always lands in the
  // low lanes regardless of addr[1:0] (no lane steering).
  logic [31:0] w_merged;

  always_comb begin
    w_merged = 32'd0;
    if (r_type[0]) begin
      w_merged = {mem_rdata[31:16], r_data[15:0]};
    end else begin
      w_merged = {mem_rdata[31:8], r_data[7:0]};
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_addr  <= 32'd0;
      r_data  <= 32'd0;
      r_type  <= 2'd0;
      r_cnt   <= 4'd0;
      r_merge <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr <= addr;
            r_data <= store_data;
            r_type <= store_type;
            if (store_type[1]) begin
              // Word store needs no read: the source value is the write data.
              r_merge <= store_data;
              r_state <= ST_WRITE;
            end else begin
              r_cnt   <= 4'd0;
              r_state <= ST_READ;
            end
          end
        end

        ST_READ: begin
          r_cnt <= r_cnt + 4'd1;
          // Counter runs 0..RD_WAIT, so READ lasts RD_WAIT+1 cycles and the
          // read data is captured in the last of them.
          if (r_cnt == c_rd_wait) begin
            r_merge <= w_merged;
            r_state <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          r_state <= ST_DONE;
        end

        ST_DONE: begin
          // start is deliberately not sampled here.
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Moore output decode: functions of state and registers only, so every
  // output drops to zero the moment reset is asserted.
  // --------------------------------------------------------------------------
  logic w_in_read;
  logic w_in_write;

  assign w_in_read  = (r_state == ST_READ);
  assign w_in_write = (r_state == ST_WRITE);

  assign busy      = w_in_read | w_in_write;
  assign done      = (r_state == ST_DONE);
  assign mem_wr    = w_in_write;
  assign mem_addr  = (w_in_read | w_in_write) ? r_addr : 32'd0;
  assign mem_wdata = w_in_write ? r_merge : 32'd0;

endmodule
`default_nettype wire
